// File: rtl/psum_requant_packer_if.sv
// Stream bundle between the MAC cluster, the requant/packer and the
// activation buffer write port. The packer side uses the slave modport.
interface psum_requant_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH  = DATA_WIDTH*2+6,
  parameter int PACK       = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [SUM_WIDTH-1:0]       in_sum;
  logic                       in_last;
  logic [4:0]                 cfg_shift;
  logic                       cfg_round;
  logic                       out_valid;
  logic                       out_ready;
  logic [PACK*DATA_WIDTH-1:0] out_data;
  logic [PACK-1:0]            out_mask;
  logic                       out_last;
  logic [15:0]                sat_count;

  modport master (
    output in_valid, in_sum, in_last, cfg_shift, cfg_round, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_last, sat_count
  );

  modport slave (
    input  in_valid, in_sum, in_last, cfg_shift, cfg_round, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_last, sat_count
  );
endinterface

// File: rtl/psum_requant_packer.sv
// Requantizes signed MAC sums to DATA_WIDTH lanes (shift, optional
// round-half-up, saturate), packs PACK lanes per word and queues words in a
// small registered FIFO toward the activation buffer.
module psum_requant_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH  = DATA_WIDTH*2+6,
  parameter int PACK       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  psum_requant_packer_if.slave bus
);
  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] MAX_SH = 5'(SUM_WIDTH-1);
  localparam logic signed [SUM_WIDTH:0] SMAX = (SUM_WIDTH+1)'(2**(DATA_WIDTH-1)-1);
  localparam logic signed [SUM_WIDTH:0] SMIN = ~SMAX;

  typedef struct packed {
    logic                       last;
    logic [PACK-1:0]            mask;
    logic [PACK*DATA_WIDTH-1:0] data;
  } word_t;

  // ---------------- requant ----------------
  logic [4:0]                 sh;
  logic signed [SUM_WIDTH:0]  ext, rnd, biased, shifted;
  logic                       clip;
  logic [DATA_WIDTH-1:0]      res;

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    sh      = (bus.cfg_shift > MAX_SH) ? MAX_SH : bus.cfg_shift;
    ext     = {bus.in_sum[SUM_WIDTH-1], bus.in_sum};
    rnd     = '0;
    if (bus.cfg_round && sh != 5'd0) rnd[sh-5'd1] = 1'b1;
    biased  = ext + rnd;
    shifted = biased >>> sh;
    clip    = 1'b0;
    res     = shifted[DATA_WIDTH-1:0];
    if (shifted > SMAX) begin
      res  = SMAX[DATA_WIDTH-1:0];
      clip = 1'b1;
    end else if (shifted < SMIN) begin
      res  = SMIN[DATA_WIDTH-1:0];
      clip = 1'b1;
    end
  end

  // ---------------- packing ----------------
  logic [PACK-1:0][DATA_WIDTH-1:0] pack_q, pack_nxt;
  logic [PACK-1:0]                 mask_q, mask_nxt;
  logic [LW-1:0]                   lane_q;
  logic                            accept, done, pop;
  logic [PW:0]                     cnt;
  logic [PW-1:0]                   wp, rp;
  word_t                           mem [FIFO_DEPTH];
  word_t                           in_word, head;

  assign accept = bus.in_valid & bus.in_ready;
  assign done   = accept & (bus.in_last | (lane_q == LW'(PACK-1)));
  assign pop    = bus.out_valid & bus.out_ready;

  // Current sample merged into the pack register; this is also the word pushed.
  always_comb begin
    pack_nxt         = pack_q;
    pack_nxt[lane_q] = res;
    mask_nxt         = mask_q;
    mask_nxt[lane_q] = 1'b1;
    in_word.last     = bus.in_last;
    in_word.mask     = mask_nxt;
    in_word.data     = pack_nxt;
  end

  // Lane counter and pack register; cleared after each pushed word so
  // unused lanes of a flushed word read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      pack_q <= '0;
      mask_q <= '0;
    end else if (done) begin
      lane_q <= '0;
      pack_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      lane_q <= lane_q + LW'(1);
      pack_q <= pack_nxt;
      mask_q <= mask_nxt;
    end
  end

  // ---------------- output FIFO ----------------
  // in_ready depends on the count only, so out_ready never reaches it
  // combinationally; a full FIFO blocks every sample.
  assign bus.in_ready  = (cnt != (PW+1)'(FIFO_DEPTH));
  assign bus.out_valid = (cnt != '0);
  assign head          = mem[rp];
  assign bus.out_data  = head.data;
  assign bus.out_mask  = head.mask;
  assign bus.out_last  = head.last;

  // FIFO storage, pointers and occupancy; storage is cleared so the head
  // reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (done) begin
        mem[wp] <= in_word;
        wp      <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      case ({done, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Saturation event counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         bus.sat_count <= '0;
    else if (accept && clip && bus.sat_count != 16'hFFFF) bus.sat_count <= bus.sat_count + 16'd1;
  end
endmodule

// File: tb/tb_psum_requant_packer.sv
// Directed bench for psum_requant_packer: packing, rounding, saturation,
// shift clamping, FIFO backpressure, mid-stream reset and sticky sat_count.
module tb_psum_requant_packer;
  typedef struct {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        last;
  } rx_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  rx_t  rx_q[$];

  always #5 clk = ~clk;

  psum_requant_packer_if #(.DATA_WIDTH(8), .SUM_WIDTH(22), .PACK(8)) bus ();

  psum_requant_packer #(.DATA_WIDTH(8), .SUM_WIDTH(22), .PACK(8), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Record every popped word; DUT state only changes in NBAs so pre-edge values are read.
  always @(posedge clk)
    if (rst_n && bus.out_valid && bus.out_ready)
      rx_q.push_back('{data: bus.out_data, mask: bus.out_mask, last: bus.out_last});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the sample until accepted, returns at the next negedge.
  task automatic send(input logic [21:0] s, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_last  = l;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_last = 1'b0;
    bus.cfg_shift = 5'd8; bus.cfg_round = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  bus.out_data, 64'd0);
    chk("rst_out_mask",  64'(bus.out_mask), 64'd0);
    chk("rst_out_last",  64'(bus.out_last), 64'd0);
    chk("rst_sat",       64'(bus.sat_count), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full word, truncating shift by 8
    for (int k = 0; k < 8; k++) begin
      send(22'(256*k), 1'b0);
      if (k == 6) chk("t1_not_yet", 64'(bus.out_valid), 64'd0);
    end
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_data",  bus.out_data, 64'h0706050403020100);
    chk("t1_mask",  64'(bus.out_mask), 64'hFF);
    chk("t1_last",  64'(bus.out_last), 64'd0);

    // 2: round half up, flushed by in_last
    bus.cfg_round = 1'b1;
    send(22'(383), 1'b0);
    send(22'(384), 1'b0);
    send(22'(-384), 1'b0);
    send(22'(-385), 1'b0);
    send(22'(0), 1'b1);
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_data",  bus.out_data, 64'h00000000FEFF0201);
    chk("t2_mask",  64'(bus.out_mask), 64'h1F);
    chk("t2_last",  64'(bus.out_last), 64'd1);

    // 3: saturation with no shift
    bus.cfg_shift = 5'd0; bus.cfg_round = 1'b0;
    send(22'(100000), 1'b0);
    send(22'(-100000), 1'b0);
    send(22'(127), 1'b0);
    send(22'(-128), 1'b1);
    chk("t3_data", bus.out_data, 64'h00000000807F807F);
    chk("t3_mask", 64'(bus.out_mask), 64'h0F);
    chk("t3_last", 64'(bus.out_last), 64'd1);
    chk("t3_sat",  64'(bus.sat_count), 64'd2);

    // 3b: shift clamped to 21, rounding add needs the extra bit, per-sample cfg
    bus.cfg_shift = 5'd31; bus.cfg_round = 1'b1;
    send(22'h1FFFFF, 1'b0);
    bus.cfg_round = 1'b0;
    send(22'h200000, 1'b1);
    chk("t3b_data", bus.out_data, 64'h000000000000FF01);
    chk("t3b_mask", 64'(bus.out_mask), 64'h03);
    chk("t3b_sat",  64'(bus.sat_count), 64'd2);
    @(negedge clk);

    // 4: backpressure with FIFO full
    rx_q.delete();
    bus.cfg_shift = 5'd0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      send(22'(k), 1'b0);
      if (k == 30) chk("t4_ready_31", 64'(bus.in_ready), 64'd1);
    end
    chk("t4_ready_full", 64'(bus.in_ready), 64'd0);
    chk("t4_head",       bus.out_data, 64'h0706050403020100);
    @(negedge clk);
    chk("t4_head_stable", bus.out_data, 64'h0706050403020100);
    chk("t4_still_full",  64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t4_ready_after_pop", 64'(bus.in_ready), 64'd1);
    chk("t4_one_popped",      64'(rx_q.size()), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 32; k < 40; k++) send(22'(k), 1'b0);
    repeat (8) @(negedge clk);
    chk("t4_words", 64'(rx_q.size()), 64'd5);
    for (int w = 0; w < 5 && w < rx_q.size(); w++) begin
      for (int j = 0; j < 8; j++) exp[8*j +: 8] = 8'(8*w + j);
      chk($sformatf("t4_w%0d_data", w), rx_q[w].data, exp);
      chk($sformatf("t4_w%0d_mask", w), 64'(rx_q[w].mask), 64'hFF);
    end

    // 5: reset mid-stream discards the queued word and the partial word
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(22'(1), 1'b0);
    for (int k = 0; k < 5; k++) send(22'(2), 1'b0);
    chk("t5_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_sat",   64'(bus.sat_count), 64'd0);
    chk("t5_rst_data",  bus.out_data, 64'd0);
    chk("t5_rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      send(22'(10 + k), 1'b0);
      if (k == 2) chk("t5_no_stale_lane", 64'(bus.out_valid), 64'd0);
    end
    chk("t5_data", bus.out_data, 64'h11100F0E0D0C0B0A);
    chk("t5_mask", 64'(bus.out_mask), 64'hFF);
    @(negedge clk);

    // 6: sticky saturation counter
    rx_q.delete();
    for (int i = 0; i < 65534; i++) send(22'(100000), 1'b0);
    chk("t6_sat_fffe", 64'(bus.sat_count), 64'hFFFE);
    send(22'(-100000), 1'b0);
    chk("t6_sat_ffff", 64'(bus.sat_count), 64'hFFFF);
    for (int i = 0; i < 5; i++) send(22'(100000), 1'b0);
    chk("t6_sat_stick", 64'(bus.sat_count), 64'hFFFF);
    repeat (2) @(negedge clk);
    chk("t6_words", 64'(rx_q.size()), 64'd8192);
    if (rx_q.size() > 0) chk("t6_first_word", rx_q[0].data, 64'h7F7F7F7F7F7F7F7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
